// File: rtl/buf_pkg.sv
// Shared helpers for the streaming FIFO: log2 sizing functions and the
// per-cycle handshake operation encoding.
package buf_pkg;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Pointer, occupancy-counter and level widths derived from the RAM depth.
    function automatic int ptr_w(input int depth);
        return clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return clog2(depth + 32'sd1);
    endfunction

    function automatic int lvl_w(input int depth);
        return clog2(depth + 32'sd2);
    endfunction

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/buf_sdp.sv
// Simple dual-port block RAM: port A writes, port B reads into a register
// that holds its value while enb is low.
module buf_sdp
    import buf_pkg::*;
#(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 128
) (
    input  logic                          clk,
    input  logic                          ena,
    input  logic                          wea,
    input  logic [clog2(RAM_DEPTH)-1:0]   addra,
    input  logic [RAM_WIDTH-1:0]          dina,
    input  logic                          enb,
    input  logic [clog2(RAM_DEPTH)-1:0]   addrb,
    output logic [RAM_WIDTH-1:0]          doutb
);

    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] doutb_q;
    logic [RAM_WIDTH-1:0] doutb_d;

    // Read register next value: load on enb, otherwise hold.
    always_comb begin
        doutb_d = doutb_q;
        if (enb) begin
            doutb_d = mem_q[addrb];
        end else begin
            doutb_d = doutb_q;
        end
    end

    // Storage and read register update.
    always_ff @(posedge clk) begin
        if (ena && wea) begin
            mem_q[addra] <= dina;
        end
        doutb_q <= doutb_d;
    end

    assign doutb = doutb_q;

endmodule

// File: rtl/buf_stream_fifo.sv
// First-word-fall-through streaming FIFO around buf_sdp, hiding its read latency.
// Optional occupancy outputs o_level/o_afull are enabled by `define BUF_FIFO_LEVEL_EN.
module buf_stream_fifo
    import buf_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 128
`ifdef BUF_FIFO_LEVEL_EN
    ,
    parameter int AFULL_LVL = DEPTH - 4
`endif
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [DATA_W-1:0]         i_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DATA_W-1:0]         o_data
`ifdef BUF_FIFO_LEVEL_EN
    ,
    output logic [lvl_w(DEPTH)-1:0]   o_level,
    output logic                      o_afull
`endif
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0] ram_cnt_q, ram_cnt_d;
    logic             out_vld_q, out_vld_d;
    logic             wr_en_s;
    logic             rd_en_s;
    logic             ready_s;
    fifo_op_e         op_s;

    // Handshake decode; ready depends only on the RAM count register.
    // Accesses are suppressed while reset is asserted so nothing lands in the RAM.
    always_comb begin
        ready_s = (ram_cnt_q != CNT_FULL);
        wr_en_s = i_valid && ready_s && i_rstn;
        rd_en_s = (ram_cnt_q != CNT_ZERO) && (!out_vld_q || i_ready) && i_rstn;
        op_s    = fifo_op_e'({wr_en_s, rd_en_s});
    end

    // Next-state for pointers, RAM count and output-valid register.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        out_vld_d = out_vld_q;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case (op_s)
            OP_WR:   ram_cnt_d = ram_cnt_q + CNT_W'(1'b1);
            OP_RD:   ram_cnt_d = ram_cnt_q - CNT_W'(1'b1);
            OP_BOTH: ram_cnt_d = ram_cnt_q;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        // A fresh read refills the output; a consume with nothing behind it empties it.
        if (rd_en_s) begin
            out_vld_d = 1'b1;
        end else if (i_ready) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            ram_cnt_q <= CNT_ZERO;
            out_vld_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            out_vld_q <= out_vld_d;
        end
    end

    buf_sdp #(
        .RAM_WIDTH (DATA_W),
        .RAM_DEPTH (DEPTH)
    ) u_ram (
        .clk   (i_clk),
        .ena   (wr_en_s),
        .wea   (wr_en_s),
        .addra (wr_ptr_q),
        .dina  (i_data),
        .enb   (rd_en_s),
        .addrb (rd_ptr_q),
        .doutb (o_data)
    );

    assign o_ready = ready_s;
    assign o_valid = out_vld_q;

`ifdef BUF_FIFO_LEVEL_EN
    localparam int LVL_W = lvl_w(DEPTH);
    logic [LVL_W-1:0] level_s;

    // Total occupancy counts the word parked in the output register too.
    always_comb begin
        level_s = LVL_W'(ram_cnt_q) + LVL_W'(out_vld_q);
        o_level = level_s;
        o_afull = (level_s >= LVL_W'(AFULL_LVL));
    end
`endif

endmodule

// File: tb/tb_buf_stream_fifo.sv
// Scoreboard bench for buf_stream_fifo: stimulus pushes accepted words,
// a negedge monitor pops and compares every consumed output word.
module tb_buf_stream_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 128;

    logic              clk = 1'b0;
    logic              i_rstn;
    logic              i_valid;
    logic              i_ready;
    logic              o_ready;
    logic              o_valid;
    logic [DATA_W-1:0] i_data;
    logic [DATA_W-1:0] o_data;
`ifdef BUF_FIFO_LEVEL_EN
    logic [7:0]        o_level;
    logic              o_afull;
`endif

    int                n_total = 0;
    int                n_pass  = 0;
    logic [7:0]        exp_q[$];
    logic              hold_r = 1'b0;
    logic [7:0]        hold_data;
    logic [7:0]        mon_exp;

    always #5 clk = ~clk;

    buf_stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_rstn  (i_rstn),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data)
`ifdef BUF_FIFO_LEVEL_EN
        ,
        .o_level (o_level),
        .o_afull (o_afull)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Drive one cycle of inputs; record the word if the DUT accepts it at the next edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r, output bit acc);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        @(negedge clk);
        acc = v && o_ready && i_rstn;
        if (acc) exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard pop on every consumed word, stability check under stall.
    always @(negedge clk) begin
        if (!i_rstn) begin
            hold_r <= 1'b0;
        end else begin
            if (hold_r) begin
                chk("stall_valid_held", o_valid, 1);
                chk("stall_data_stable", o_data, hold_data);
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", o_data, -1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("sb_data", o_data, mon_exp);
                end
            end
            hold_r    <= o_valid && !i_ready;
            hold_data <= o_data;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int nacc;
        int seen;
        int gaps;
        int err_a;
        int err_b;
        int wait_cnt;
`ifdef BUF_FIFO_LEVEL_EN
        int lvl_err;
        int afull_err;
`endif

        i_rstn  = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        i_rstn = 1'b1;

        // Reset state
        chk("reset_o_valid", o_valid, 0);
        chk("reset_o_ready", o_ready, 1);
`ifdef BUF_FIFO_LEVEL_EN
        chk("reset_o_level", o_level, 0);
        chk("reset_o_afull", o_afull, 0);
`endif

        // Single word: written at edge t, visible only in cycle t+2
        step(1'b1, 8'hA5, 1'b1, acc);
        chk("single_accept", acc, 1);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        chk("single_t1_valid", o_valid, 0);
        @(negedge clk);
        chk("single_t2_valid", o_valid, 1);
        chk("single_t2_data", o_data, 8'hA5);
        @(negedge clk);
        chk("single_t3_valid", o_valid, 0);
        @(posedge clk);
        #1;

        // Fill with consumer stalled: DEPTH+1 words fit
        nacc = 0;
`ifdef BUF_FIFO_LEVEL_EN
        lvl_err   = 0;
        afull_err = 0;
`endif
        for (int k = 0; k <= DEPTH; k++) begin
            step(1'b1, 8'(k), 1'b0, acc);
            nacc += int'(acc);
`ifdef BUF_FIFO_LEVEL_EN
            if (o_level != 8'(nacc)) lvl_err++;
            if (o_afull != (nacc >= 124)) afull_err++;
`endif
        end
        chk("fill_accepts", nacc, 129);
        chk("fill_ready_low", o_ready, 0);
`ifdef BUF_FIFO_LEVEL_EN
        chk("fill_level", o_level, 129);
        chk("fill_afull", o_afull, 1);
        chk("fill_level_track_errs", lvl_err, 0);
        chk("fill_afull_track_errs", afull_err, 0);
`endif
        step(1'b1, 8'hEE, 1'b0, acc);
        chk("full_no_write", acc, 0);
        chk("full_ready_still_low", o_ready, 0);

        // Drain with consumer ready: 129 words, no gaps
        i_valid = 1'b0;
        i_ready = 1'b1;
        seen = 0;
        gaps = 0;
        for (int c = 0; c < 300 && seen < 129; c++) begin
            @(negedge clk);
            if (o_valid) seen++;
            else if (seen > 0) gaps++;
        end
        chk("drain_count", seen, 129);
        chk("drain_gaps", gaps, 0);
        @(posedge clk);
        #1;
        chk("drain_sb_empty", exp_q.size(), 0);
        chk("drain_ready_high", o_ready, 1);

        // Simultaneous write and read, 300 words, pointers wrap twice
        err_a = 0;
        err_b = 0;
        for (int k = 0; k < 300; k++) begin
            step(1'b1, 8'(k * 3 + 1), 1'b1, acc);
            if (!acc) err_a++;
            if (k >= 1 && !o_valid) err_b++;
`ifdef BUF_FIFO_LEVEL_EN
            if (k >= 1 && o_level != 8'd2) lvl_err++;
`endif
        end
        chk("stream_accept_misses", err_a, 0);
        chk("stream_valid_gaps", err_b, 0);
`ifdef BUF_FIFO_LEVEL_EN
        chk("stream_level_const_errs", lvl_err, 0);
`endif
        repeat (4) step(1'b0, 8'h00, 1'b1, acc);
        chk("stream_sb_empty", exp_q.size(), 0);

        // Random backpressure: 70% valid, 50% ready, 2000 words
        nacc = 0;
        for (int c = 0; c < 20000 && nacc < 2000; c++) begin
            step(($urandom_range(99) < 70), 8'($urandom), ($urandom_range(99) < 50), acc);
            nacc += int'(acc);
        end
        chk("random_accepts", nacc, 2000);
        i_valid = 1'b0;
        i_ready = 1'b1;
        wait_cnt = 0;
        while ((exp_q.size() != 0 || o_valid) && wait_cnt < 500) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        chk("random_sb_empty", exp_q.size(), 0);

        // Mid-operation reset with 40 words stored and a read in flight
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 8'(k + 64), 1'b0, acc);
        end
        step(1'b0, 8'h00, 1'b1, acc);
        i_rstn = 1'b0;
        exp_q.delete();
        step(1'b0, 8'h00, 1'b1, acc);
        i_rstn = 1'b1;
        chk("midrst_o_valid", o_valid, 0);
        chk("midrst_o_ready", o_ready, 1);
`ifdef BUF_FIFO_LEVEL_EN
        chk("midrst_o_level", o_level, 0);
`endif
        step(1'b1, 8'h3C, 1'b1, acc);
        step(1'b1, 8'h3D, 1'b1, acc);
        i_valid = 1'b0;
        wait_cnt = 0;
        @(negedge clk);
        while (!o_valid && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("midrst_first_word", o_data, 8'h3C);
        @(posedge clk);
        #1;
        repeat (4) step(1'b0, 8'h00, 1'b1, acc);
        chk("midrst_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/buf_stream_fifo.md
# buf_stream_fifo

Streaming FIFO controller that sits directly upstream of the datapath consumer and wraps the team's simple dual-port block-RAM buffer (`buf_sdp`). It accepts words on a valid/ready input, stores them in the SDP RAM, and presents them first-word-fall-through on a valid/ready output. It hides the RAM's 1-cycle registered read latency. Pointer, count and handshake logic live here; storage lives in the RAM sub-module.

## Interface
- `DATA_W`, default 8: word width in bits.
- `DEPTH`, default 128: RAM entries; must be a power of 2 and at least 4.
- `AFULL_LVL`, default `DEPTH-4`: almost-full threshold (only with `BUF_FIFO_LEVEL_EN`).
- `i_clk`, input, 1: single clock; all logic on its rising edge.
- `i_rstn`, input, 1: reset, synchronous, active-low.
- `i_valid`, input, 1: input word valid.
- `o_ready`, output, 1: FIFO can accept a word.
- `i_data`, input, `DATA_W`: input word.
- `o_valid`, output, 1: output word valid.
- `i_ready`, input, 1: consumer accepts the output word.
- `o_data`, output, `DATA_W`: output word; driven directly by the RAM read register.
- `o_level`, output, `clog2(DEPTH+2)`: occupancy (only with `BUF_FIFO_LEVEL_EN`).
- `o_afull`, output, 1: almost-full flag (only with `BUF_FIFO_LEVEL_EN`).

## Operation
- **Registers:**
  - `wr_ptr` and `rd_ptr` are `clog2(DEPTH)` bits and wrap modulo `DEPTH` naturally.
  - `ram_cnt` is `clog2(DEPTH+1)` bits.
  - `out_vld` drives `o_valid`.
- **Write:**
  - A write occurs when `i_valid && o_ready`.
  - The RAM sees `ena=wea=1`, `addra=wr_ptr`, `dina=i_data`.
  - `wr_ptr` increments.
- **Ready:** `o_ready = (ram_cnt != DEPTH)`. It is a function of registers only; there is no combinational path from `i_ready`.
- **Read issue:**
  - A read is issued when `rd_en = (ram_cnt != 0) && (!out_vld || i_ready)`.
  - The RAM sees `enb=rd_en`, `addrb=rd_ptr`.
  - `rd_ptr` increments on `rd_en`.
- **Output:**
  - `out_vld` next value:
    - 1 if `rd_en`;
    - else 0 if `i_ready`;
    - else hold.
  - While `enb=0` the RAM read register holds, so `o_data` stays stable while `o_valid && !i_ready`.
- **Count:** `ram_cnt` next = `ram_cnt + write − rd_en`. A simultaneous write and read leaves it unchanged.
- **Capacity:** `DEPTH` words in RAM plus one in the output register, i.e. `DEPTH+1` total.
- **Full with consumer reading:** `o_ready` rises one cycle after the read frees a RAM entry. No write-through when full.
- **Empty with writer:** there is no bypass path. A word always passes through the RAM.
- **Reset:**
  - While `i_rstn=0` at a clock edge, the following registers clear to 0: `wr_ptr`, `rd_ptr`, `ram_cnt`, `out_vld`.
  - `o_valid=0` and `o_ready=1` from the first cycle after the reset edge.
  - Reset mid-operation discards all stored words and any read in flight.
  - `o_data` is not reset and is don't-care while `o_valid=0`.
- **Protocol:** `i_valid`/`i_data` are not required to be held, because accept is visible combinationally via `o_ready`.

## Timing
- **Write-to-output latency:**
  - A word written at edge t makes `ram_cnt ≥ 1` in cycle t+1.
  - The read is issued in t+1.
  - `o_valid=1` with the word on `o_data` in t+2.
  - Empty-to-valid latency is therefore 2 cycles.
- **RAM read-after-write:** a read of address k one cycle after the write to k returns the new data, because the write lands at edge t and the read samples at edge t+1.
- **Throughput:**
  - Sustained 1 word/cycle in and out once primed.
  - Back-to-back output with `i_ready=1` continuously when `ram_cnt>0`.
- **Backpressure:**
  - `i_ready=0` with `o_valid=1` stalls reads.
  - `ram_cnt` grows until `o_ready` falls at `ram_cnt=DEPTH`.

## Configuration
- Macro: `BUF_FIFO_LEVEL_EN`.
- **Defined:**
  - Ports `o_level` and `o_afull` exist.
  - `o_level = ram_cnt + out_vld`; reset value 0.
  - `o_afull = (o_level >= AFULL_LVL)`; reset value 0.
  - Both outputs are registered-derived with no `i_ready` path.
- **Undefined:** ports and parameter `AFULL_LVL` are absent. Core behaviour is identical.

## Structure
- Shared package `buf_pkg` holds:
  - the `clog2` constant function;
  - the pointer/count width derivations, as localparam helpers.
- One sub-module: `buf_sdp` (`RAM_WIDTH=DATA_W`, `RAM_DEPTH=DEPTH`), instantiated as `u_ram`.
- All control (pointers, count, `out_vld`, level) lives in `buf_stream_fifo`; the RAM must not be modified.

## Test plan
- **Reset:** hold `i_rstn=0` 3 cycles, then release → `o_valid=0`, `o_ready=1`, `o_level=0`.
- **Single word:** write 0xA5 at edge t with `i_ready=1` → `o_valid=1`, `o_data=0xA5` in cycle t+2 only; `o_valid=0` at t+3.
- **Fill:**
  - With `i_ready=0`, stream 0..DEPTH (129 words) → `o_ready=0` after the 129th accept.
  - `o_level=129`, `o_afull=1` from `o_level≥124`.
  - Then `i_ready=1` → outputs 0x00..0x80 in order, no gaps after the first.
- **Simultaneous:** continuous write and read at 1 word/cycle over 300 words, with pointers wrapping twice → output sequence equals input, `ram_cnt` constant.
- **Random backpressure:** 50% `i_ready` and 70% `i_valid` over 2000 words → scoreboard exact order; `o_data` stable whenever `o_valid && !i_ready`.
- **Mid-operation reset:** assert `i_rstn=0` for 1 cycle with 40 words stored and a read in flight → `o_valid=0` the next cycle, `o_level=0`; the next written word 0x3C is the first word out.
